// File: rtl/control_cmd_fillarea_pkg.sv
// Shared types and sizes for the fill-area command front end.
// The payload struct mirrors the on-wire byte order: x1, y1, width, height, colour MSB first.
package control_cmd_fillarea_pkg;

    localparam int BYTES_PER_PIXEL        = 3;
    localparam int FILLAREA_PAYLOAD_BYTES = 4 + BYTES_PER_PIXEL;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        CHECK,
        LAUNCH,
        WAIT_SUB,
        DONE
    } fillarea_cmd_state_t;

    typedef struct packed {
        logic [7:0]                   x1;
        logic [7:0]                   y1;
        logic [7:0]                   width;
        logic [7:0]                   height;
        logic [BYTES_PER_PIXEL*8-1:0] color;
    } fillarea_payload_t;

    // One axis of the rectangle: origin on the panel, non-empty, and not running off the edge.
    // The sum is formed at 9 bits so byte values near 255 cannot wrap.
    function automatic logic rect_fits(input logic [7:0] org, input logic [7:0] len,
                                       input logic [8:0] span);
        logic [8:0] sum;
        sum = {1'b0, org} + {1'b0, len};
        return ({1'b0, org} < span) && (len != 8'd0) && (sum <= span);
    endfunction

endpackage

// File: rtl/control_cmd_fillarea_payload_collector.sv
// Purpose: shifts in a fixed-length multi-byte payload, first byte ends up in the top byte.
// Latency: complete is combinational on the strobe of the final byte; payload is valid next cycle.
// Backpressure: none; the caller gates shift_en and may clear a partial payload at any time.
module control_payload_collector #(
    parameter int NUM_BYTES = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   shift_en,
    input  logic [7:0]             data_in,
    output logic [NUM_BYTES*8-1:0] payload,
    output logic                   complete
);

    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    logic [IDX_W-1:0] byte_idx;

    assign complete = shift_en && (byte_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_idx <= '0;
            payload  <= '0;
        end else if (clear) begin
            byte_idx <= '0;
        end else if (shift_en) begin
            payload  <= {payload[NUM_BYTES*8-9:0], data_in};
            byte_idx <= complete ? '0 : byte_idx + 1'b1;
        end
    end

endmodule

// File: rtl/control_cmd_fillarea.sv
// Purpose: collects the fill-area payload, range-checks it and runs the subcommand handshake.
// Latency: last payload byte to subcmd_enable (accept) or done (reject) is 2 cycles.
// Backpressure: done/error held until ack; enable low while collecting aborts the command.
module control_cmd_fillarea
    import control_cmd_fillarea_pkg::*;
#(
    parameter int PIXEL_WIDTH              = 64,
    parameter int PIXEL_HEIGHT             = 32,
    parameter int _NUM_COLUMN_ADDRESS_BITS = $clog2(PIXEL_WIDTH),
    parameter int _NUM_ROW_ADDRESS_BITS    = $clog2(PIXEL_HEIGHT)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [7:0]                          data_in,
    input  logic                                data_valid,
    input  logic                                ack,
    output logic                                done,
    output logic                                error,
    output logic                                subcmd_enable,
    input  logic                                subcmd_done,
    output logic                                subcmd_ack,
    output logic [_NUM_COLUMN_ADDRESS_BITS-1:0] x1,
    output logic [_NUM_ROW_ADDRESS_BITS-1:0]    y1,
    output logic [_NUM_COLUMN_ADDRESS_BITS-1:0] width,
    output logic [_NUM_ROW_ADDRESS_BITS-1:0]    height,
    output logic [BYTES_PER_PIXEL*8-1:0]        color
);

    fillarea_cmd_state_t state;

    logic                                  capture;
    logic                                  abort;
    logic                                  last_byte;
    logic                                  accept;
    logic [FILLAREA_PAYLOAD_BYTES*8-1:0]   payload;
    fillarea_payload_t                     pl;

    // The first enable cycle may already carry byte 0, so IDLE captures as well as RECV.
    assign capture = data_valid && enable && ((state == IDLE) || (state == RECV));
    assign abort   = (state == RECV) && !enable;

    control_payload_collector #(
        .NUM_BYTES (FILLAREA_PAYLOAD_BYTES)
    ) u_collector (
        .clk      (clk),
        .reset    (reset),
        .clear    (abort),
        .shift_en (capture),
        .data_in  (data_in),
        .payload  (payload),
        .complete (last_byte)
    );

    assign pl     = payload;
    assign accept = rect_fits(pl.x1, pl.width,  9'(PIXEL_WIDTH)) &&
                    rect_fits(pl.y1, pl.height, 9'(PIXEL_HEIGHT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            done          <= 1'b0;
            error         <= 1'b0;
            subcmd_enable <= 1'b0;
            subcmd_ack    <= 1'b0;
            x1            <= '0;
            y1            <= '0;
            width         <= '0;
            height        <= '0;
            color         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= last_byte ? CHECK : RECV;
                    end
                end
                RECV: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (last_byte) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        // Truncation makes a full-span width/height encode as 0.
                        x1            <= pl.x1[_NUM_COLUMN_ADDRESS_BITS-1:0];
                        y1            <= pl.y1[_NUM_ROW_ADDRESS_BITS-1:0];
                        width         <= pl.width[_NUM_COLUMN_ADDRESS_BITS-1:0];
                        height        <= pl.height[_NUM_ROW_ADDRESS_BITS-1:0];
                        color         <= pl.color;
                        subcmd_enable <= 1'b1;
                        state         <= LAUNCH;
                    end else begin
                        done  <= 1'b1;
                        error <= 1'b1;
                        state <= DONE;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_SUB;
                end
                WAIT_SUB: begin
                    // subcmd_ack doubles as the "done already seen" marker for the release cycle.
                    if (subcmd_ack) begin
                        subcmd_ack    <= 1'b0;
                        subcmd_enable <= 1'b0;
                        done          <= 1'b1;
                        error         <= 1'b0;
                        state         <= DONE;
                    end else if (subcmd_done) begin
                        subcmd_ack <= 1'b1;
                    end
                end
                DONE: begin
                    if (ack) begin
                        done  <= 1'b0;
                        error <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_cmd_fillarea.sv
// Randomised bench for the fill-area command front end on a 4x4 panel with a window-based reference model.
module tb_control_cmd_fillarea;
    import control_cmd_fillarea_pkg::*;

    localparam int PW = 4;
    localparam int PH = 4;
    localparam int CB = $clog2(PW);
    localparam int RB = $clog2(PH);
    localparam int NB = FILLAREA_PAYLOAD_BYTES;
    localparam int CW = BYTES_PER_PIXEL * 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [7:0]    data_in;
    logic          data_valid;
    logic          ack;
    logic          done;
    logic          error;
    logic          subcmd_enable;
    logic          subcmd_done;
    logic          subcmd_ack;
    logic [CB-1:0] x1;
    logic [RB-1:0] y1;
    logic [CB-1:0] width;
    logic [RB-1:0] height;
    logic [CW-1:0] color;

    always #5 clk = ~clk;

    control_cmd_fillarea #(
        .PIXEL_WIDTH  (PW),
        .PIXEL_HEIGHT (PH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .ack           (ack),
        .done          (done),
        .error         (error),
        .subcmd_enable (subcmd_enable),
        .subcmd_done   (subcmd_done),
        .subcmd_ack    (subcmd_ack),
        .x1            (x1),
        .y1            (y1),
        .width         (width),
        .height        (height),
        .color         (color)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: cycle windows in which each output must be high, plus expected fields.
    int            en_lo = 1, en_hi = 0, ack_at = -1, dn_lo = 1, dn_hi = 0, fld_lo = 1, fld_hi = 0;
    bit            exp_err_v = 1'b0;
    logic [CB-1:0] e_x1, e_w;
    logic [RB-1:0] e_y1, e_h;
    logic [CW-1:0] e_col;
    bit            chk_on = 1'b0;

    always @(negedge clk) begin : cmp
        bit in_dn;
        if (chk_on) begin
            in_dn = (cyc >= dn_lo) && (cyc <= dn_hi);
            chk("subcmd_enable", 64'(subcmd_enable), 64'((cyc >= en_lo) && (cyc <= en_hi)));
            chk("subcmd_ack", 64'(subcmd_ack), 64'(cyc == ack_at));
            chk("done", 64'(done), 64'(in_dn));
            chk("error", 64'(error), 64'(in_dn && exp_err_v));
            if ((cyc >= fld_lo) && (cyc <= fld_hi)) begin
                chk("x1", 64'(x1), 64'(e_x1));
                chk("y1", 64'(y1), 64'(e_y1));
                chk("width", 64'(width), 64'(e_w));
                chk("height", 64'(height), 64'(e_h));
                chk("color", 64'(color), 64'(e_col));
            end
        end
    end

    function automatic bit model_accept(input int x, input int y, input int w, input int h);
        return (x < PW) && (y < PH) && (w > 0) && (h > 0) && (x + w <= PW) && (y + h <= PH);
    endfunction

    logic [7:0]    pay [NB];
    logic          seen_en, seen_done, seen_err, any_en;
    logic [CB-1:0] seen_x1, seen_w;
    logic [RB-1:0] seen_y1, seen_h;
    logic [CW-1:0] seen_col;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input bit same_first, input bit rst_mid);
        int idx, L, D, A, R;
        bit acc;
        logic [CW-1:0] col;
        tick();
        enable = 1'b1; data_valid = 1'b0; idx = 0;
        if (same_first) begin
            data_valid = 1'b1; data_in = pay[0]; idx = 1;
        end
        while (idx < NB) begin
            tick();
            if ($urandom_range(0, 2) == 0) begin
                data_valid = 1'b0; data_in = 8'($urandom);
            end else begin
                data_valid = 1'b1; data_in = pay[idx]; idx++;
            end
        end
        L = cyc;
        acc = model_accept(int'(pay[0]), int'(pay[1]), int'(pay[2]), int'(pay[3]));
        col = '0;
        for (int k = 0; k < BYTES_PER_PIXEL; k++) col = (col << 8) | CW'(pay[4 + k]);
        D = -10; R = -1;
        if (acc) begin
            D = L + 3 + (rst_mid ? 8 : int'($urandom_range(0, 3)));
            A = D + 2 + int'($urandom_range(0, 3));
            en_lo = L + 2; en_hi = D + 1; ack_at = D + 1;
            dn_lo = D + 2; dn_hi = A;
            fld_lo = L + 2; fld_hi = A;
            e_x1 = CB'(int'(pay[0]) % PW); e_y1 = RB'(int'(pay[1]) % PH);
            e_w  = CB'(int'(pay[2]) % PW); e_h  = RB'(int'(pay[3]) % PH);
            e_col = col;
            if (rst_mid) begin
                R = L + 3 + int'($urandom_range(0, 3));
                en_hi = R; ack_at = -1; dn_lo = 1; dn_hi = 0; fld_hi = R;
            end
        end else begin
            A = L + 2 + int'($urandom_range(0, 3));
            en_lo = 1; en_hi = 0; ack_at = -1; fld_lo = 1; fld_hi = 0;
            dn_lo = L + 2; dn_hi = A;
        end
        exp_err_v = !acc;
        any_en = 1'b0; seen_en = 1'b0; seen_done = 1'b0; seen_err = 1'b0;
        seen_x1 = '1; seen_y1 = '1; seen_w = '1; seen_h = '1; seen_col = '1;
        forever begin
            tick();
            data_valid  = 1'($urandom_range(0, 1));
            data_in     = 8'($urandom);
            subcmd_done = acc && ((cyc == D) || (cyc == D + 1));
            ack         = (cyc == A);
            enable      = (cyc < A) ? 1'($urandom_range(0, 1)) : 1'b0;
            any_en      = any_en | subcmd_enable;
            if (cyc == L + 2) begin
                seen_en = subcmd_enable; seen_done = done; seen_err = error;
                seen_x1 = x1; seen_y1 = y1; seen_w = width; seen_h = height; seen_col = color;
            end
            if (cyc == R) begin
                reset = 1'b1;
                break;
            end
            if (cyc == A) break;
        end
        tick();
        reset = 1'b0; ack = 1'b0; enable = 1'b0; subcmd_done = 1'b0; data_valid = 1'b0;
        if (R >= 0) begin
            chk("rst_subcmd_enable", 64'(subcmd_enable), 64'(0));
            chk("rst_done", 64'(done), 64'(0));
            chk("rst_color", 64'(color), 64'(0));
        end
        repeat ($urandom_range(0, 2)) begin
            tick();
            data_valid = 1'($urandom_range(0, 1)); data_in = 8'($urandom);
        end
    endtask

    task automatic run_abort(input int n);
        int cnt;
        tick();
        enable = 1'b1; data_valid = 1'b0; cnt = 0;
        while (cnt < n) begin
            tick();
            if ($urandom_range(0, 2) == 0) begin
                data_valid = 1'b0;
            end else begin
                data_valid = 1'b1; data_in = 8'($urandom); cnt++;
            end
        end
        tick();
        enable = 1'b0; data_valid = 1'($urandom_range(0, 1)); data_in = 8'($urandom);
        tick();
        data_valid = 1'b0;
    endtask

    task automatic set_pay(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input logic [23:0] col);
        pay[0] = a; pay[1] = b; pay[2] = c; pay[3] = d;
        for (int k = 0; k < BYTES_PER_PIXEL; k++) pay[4 + k] = col[8*(BYTES_PER_PIXEL-1-k) +: 8];
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; data_in = 8'h00; data_valid = 1'b0;
        ack = 1'b0; subcmd_done = 1'b0;
        tick(); tick();
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_error", 64'(error), 64'(0));
        chk("reset_subcmd_enable", 64'(subcmd_enable), 64'(0));
        chk("reset_subcmd_ack", 64'(subcmd_ack), 64'(0));
        chk("reset_fields", 64'({x1, y1, width, height, color}), 64'(0));
        reset = 1'b0;
        chk_on = 1'b1;

        // Full panel: full-span width/height encode as 0.
        set_pay(8'd0, 8'd0, 8'd4, 8'd4, 24'h000000);
        run_txn(1'b0, 1'b0);
        chk("full_launch_at_2", 64'(seen_en), 64'(1));
        chk("full_fields", 64'({seen_x1, seen_y1, seen_w, seen_h, seen_col}), 64'(0));

        // Sub-rectangle with colour bytes MSB first.
        set_pay(8'd1, 8'd2, 8'd2, 8'd1, 24'hAABBCC);
        run_txn(1'b0, 1'b0);
        chk("sub_x1", 64'(seen_x1), 64'(1));
        chk("sub_y1", 64'(seen_y1), 64'(2));
        chk("sub_width", 64'(seen_w), 64'(2));
        chk("sub_height", 64'(seen_h), 64'(1));
        chk("sub_color", 64'(seen_col), 64'(24'hAABBCC));

        // Rejections: overflow past the right edge, then zero width.
        set_pay(8'd3, 8'd0, 8'd2, 8'd1, 24'h123456);
        run_txn(1'b0, 1'b0);
        chk("rej_ovf_done_at_2", 64'({seen_done, seen_err}), 64'(2'b11));
        chk("rej_ovf_no_subcmd", 64'(any_en), 64'(0));
        set_pay(8'd0, 8'd0, 8'd0, 8'd1, 24'h654321);
        run_txn(1'b0, 1'b0);
        chk("rej_w0_done_at_2", 64'({seen_done, seen_err}), 64'(2'b11));
        chk("rej_w0_no_subcmd", 64'(any_en), 64'(0));

        // Abort after 3 bytes, then a complete payload whose byte 0 rides the first enable cycle.
        run_abort(3);
        set_pay(8'd1, 8'd1, 8'd3, 8'd2, 24'h0F1E2D);
        run_txn(1'b1, 1'b0);
        chk("post_abort_fields", 64'({seen_x1, seen_y1, seen_w, seen_h}), 64'({2'd1, 2'd1, 2'd3, 2'd2}));
        chk("post_abort_color", 64'(seen_col), 64'(24'h0F1E2D));

        // Reset while waiting on the subcommand.
        set_pay(8'd0, 8'd1, 8'd2, 8'd3, 24'hC0FFEE);
        run_txn(1'b0, 1'b1);

        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                run_abort(int'($urandom_range(1, NB - 1)));
            end else begin
                for (int k = 0; k < 4; k++)
                    pay[k] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
                for (int k = 4; k < NB; k++) pay[k] = 8'($urandom);
                run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
            end
        end

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_cmd_fillarea.md
Name: control_cmd_fillarea

Overview:
Command-level front end for the fill-area operation.
- Collects the fill-area payload bytes from the control byte stream.
- Range-checks the rectangle, then drives control_subcmd_fillarea through its enable/done/ack handshake.
- Reports completion, with a status flag, to the parent control FSM.
- Sits between the control command dispatcher (upstream) and control_subcmd_fillarea (downstream).

Parameters:
- PIXEL_WIDTH, 64: panel columns; must be a power of two ≥ 2.
- PIXEL_HEIGHT, 32: panel rows; must be a power of two ≥ 2.
- _NUM_COLUMN_ADDRESS_BITS, $clog2(PIXEL_WIDTH): derived, do not override.
- _NUM_ROW_ADDRESS_BITS, $clog2(PIXEL_HEIGHT): derived, do not override.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  held high by the dispatcher for the whole command.
- data_in  in  8  payload byte.
- data_valid  in  1  byte strobe; one byte per high cycle.
- ack  in  1  parent acknowledges done.
- done  out  1  command complete; held until ack.
- error  out  1  valid while done=1; 1 = payload rejected, no fill issued.
- subcmd_enable  out  1  to control_subcmd_fillarea.enable.
- subcmd_done  in  1  from control_subcmd_fillarea.done.
- subcmd_ack  out  1  to control_subcmd_fillarea.ack.
- x1  out  _NUM_COLUMN_ADDRESS_BITS  rectangle origin column.
- y1  out  _NUM_ROW_ADDRESS_BITS  rectangle origin row.
- width  out  _NUM_COLUMN_ADDRESS_BITS  rectangle width.
- height  out  _NUM_ROW_ADDRESS_BITS  rectangle height.
- color  out  BYTES_PER_PIXEL*8  fill colour.

Behaviour:
- Payload layout: FILLAREA_PAYLOAD_BYTES = 4 + BYTES_PER_PIXEL bytes, in order x1, y1, width, height, then colour bytes MSB first.
- Reset:
  - All outputs go to 0 on the next clk edge and the state goes to IDLE.
  - This applies in every state, including mid-fill; downstream is then released by subcmd_enable=0.
- IDLE:
  - Waits for enable=1 and goes to RECV.
  - A data_valid in the same cycle as the first enable=1 cycle is captured as byte 0.
- RECV:
  - Each data_valid stores data_in into the field selected by byte_idx, then increments byte_idx.
  - After byte FILLAREA_PAYLOAD_BYTES-1 is stored, go to CHECK.
  - enable=0 in RECV aborts to IDLE: no done, no subcmd activity, byte_idx cleared.
- CHECK (1 cycle): reject (error=1, go to DONE) when any of the following holds:
  - x1_byte ≥ PIXEL_WIDTH;
  - y1_byte ≥ PIXEL_HEIGHT;
  - width_byte = 0 or height_byte = 0;
  - x1_byte + width_byte > PIXEL_WIDTH, compared at 9-bit width;
  - y1_byte + height_byte > PIXEL_HEIGHT, compared at 9-bit width.
- CHECK, accept path:
  - Output fields are the bytes truncated to address width, so width = PIXEL_WIDTH encodes as 0 (full span) and the same holds for height.
  - Go to LAUNCH.
- Output stability: x1, y1, width, height and color are registered and stable from LAUNCH until the return to IDLE.
- LAUNCH: subcmd_enable=1; go to WAIT_SUB.
- WAIT_SUB:
  - Hold subcmd_enable=1 until subcmd_done=1.
  - On the cycle after subcmd_done is first seen high: subcmd_ack=1 for exactly one cycle.
  - Next cycle: subcmd_ack=0 and subcmd_enable=0; go to DONE with error=0.
- DONE:
  - done=1, error held.
  - On ack=1: next cycle done=0, error=0, and the state returns to IDLE.
  - Re-entry needs enable seen high again after the return to IDLE.
- Ignored inputs:
  - data_valid outside RECV is ignored and does not shift byte_idx.
  - enable dropping in LAUNCH, WAIT_SUB or DONE is ignored; the fill always completes its handshake.
- Latency: last payload byte to subcmd_enable=1 is 2 cycles; a rejected payload reaches done=1 in 2 cycles.
- subcmd_ack is never asserted unless subcmd_done=1 was observed first.

Decomposition:
- params_pkg gains FILLAREA_PAYLOAD_BYTES.
- params_pkg gains a fillarea_cmd_state_t enum: IDLE, RECV, CHECK, LAUNCH, WAIT_SUB, DONE.
- The byte-field capture is a natural sub-module, control_payload_collector, parameterised on byte count.
  - It has shift-in with a byte counter and a complete pulse.
  - It is reusable by other multi-byte commands.
- The FSM and range check stay in this module.

Test Plan:
- Full panel: PIXEL_WIDTH=4, PIXEL_HEIGHT=4, payload {0,0,4,4,colour 0x00…} → x1=0, y1=0, width=0, height=0, color=0. Also:
  - subcmd_enable rises 2 cycles after the last byte.
  - Paired with the real control_subcmd_fillarea, all valid RAM bytes become 0 and done=1, error=0.
- Sub-rectangle: {1,2,2,1,colour 0xAABBCC} → x1=1, y1=2, width=2, height=1, color=0xAABBCC.
  - subcmd_ack is one cycle high exactly 1 cycle after subcmd_done.
- Rejection: {3,0,2,1,…} on the 4-wide panel (overflow) → done=1, error=1 within 2 cycles, subcmd_enable never asserted.
  - Repeat with width_byte=0: same result.
- Abort: enable drops after 3 bytes → no done and no subcmd_enable.
  - A following complete payload is then accepted correctly, with no stale byte offset.
- Reset mid-fill: reset asserted during WAIT_SUB → next cycle subcmd_enable=0, done=0 and state=IDLE.
  - Downstream returns to idle within 1 cycle.
- Byte strobe on the first enable cycle plus stray data_valid during WAIT_SUB → byte 0 captured, stray bytes ignored, fields unchanged.
